fec_fabric_snk: RTL and testbench
=================================

FEC_FABRIC_SNK -- requirements
Module: fec_fabric_snk

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning log2 of payload FIFO depth (16 entries).
REQ-002 SHALL have parameter MAX_WORDS, default 759, meaning maximum legal frame length in 16-bit words.
REQ-003 SHALL have clk_sys_i  in  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have rst_sys_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have snk_cyc_i, snk_stb_i, snk_we_i  in  1 each  pipelined Wishbone fabric sink controls.
REQ-006 SHALL have snk_adr_i  in  2  word type: 0 data, 1 OOB, 2 status, 3 user.
REQ-007 SHALL have snk_dat_i  in  16  fabric word.
REQ-008 SHALL have snk_sel_i  in  2  byte select; 2'b01 on a data word marks an odd final byte.
REQ-009 SHALL have snk_ack_o, snk_stall_o  out  1 each  fabric ack and stall.
REQ-010 SHALL have pld_dat_o  out  16, pld_last_o  out  1, pld_err_o  out  1, pld_valid_o  out  1, pld_ready_i  in  1  payload stream to the FEC encoder.
REQ-011 SHALL have hdr_etype_o  out  16, hdr_valid_o  out  1  ethertype plus one-cycle strobe.

Function
REQ-012 A beat SHALL be accepted when snk_cyc_i & snk_stb_i & snk_we_i & !snk_stall_o; snk_ack_o SHALL pulse exactly one cycle after each accepted beat.
REQ-013 snk_stall_o SHALL be high while FIFO occupancy >= 2^FIFO_AW - 2, or while the FSM is in FLUSH.
REQ-014 FSM states: IDLE, HDR, PLD, FLUSH; IDLE->HDR on snk_cyc_i rising; HDR->PLD after data word 6 accepted; HDR/PLD->FLUSH on snk_cyc_i falling; FLUSH->IDLE after one cycle.
REQ-015 Data words (adr 0) SHALL be counted from 0; word 6 SHALL load hdr_etype_o and pulse hdr_valid_o the following cycle.
REQ-016 Each data word SHALL be held in a one-entry pending register and pushed to the FIFO with last=0 when the next data word arrives; in FLUSH the pending word SHALL be pushed with last=1.
REQ-017 OOB and user words SHALL be acked but not stored.
REQ-018 A status word with bit 1 set SHALL latch the frame error flag.
REQ-019 The frame error flag SHALL also latch on a runt (fewer than 7 data words) or when the word count exceeds MAX_WORDS; it SHALL be emitted as pld_err_o on the last entry and cleared in IDLE.
REQ-020 The word counter SHALL be 11 bits, saturating at 2047.
REQ-021 A cycle with zero data words SHALL push nothing.
REQ-022 Words beyond MAX_WORDS SHALL be acked and discarded.
REQ-023 The FIFO SHALL be first-word-fall-through: pld_valid_o = !empty; an entry pops when pld_valid_o & pld_ready_i.
REQ-024 On a simultaneous push and pop, occupancy SHALL be unchanged.
REQ-025 An accepted beat arriving while snk_cyc_i is falling SHALL be ignored.

Reset
REQ-026 rst_sys_i SHALL clear the FSM to IDLE, flush the FIFO, and clear the pending register, counter and error flag.
REQ-027 While rst_sys_i is asserted, outputs SHALL be: snk_ack_o 0, snk_stall_o 1, pld_valid_o 0, pld_last_o 0, pld_err_o 0, hdr_valid_o 0, hdr_etype_o 16'h0000, pld_dat_o 16'h0000.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no last entry is emitted for it.

Configuration
REQ-029 With FEC_FABRIC_SNK_HDR_STRIP_EN defined, data words 0-6 SHALL NOT be pushed to the FIFO; a runt then emits nothing to the FIFO.
REQ-030 Without FEC_FABRIC_SNK_HDR_STRIP_EN, all data words SHALL be pushed; hdr_* behaviour is identical in both builds.

Structure
REQ-031 Package fec_pkg SHALL hold the fabric address constants (C_ADR_DATA/OOB/STATUS/USER), the status error bit index, the state enum, and the FIFO entry struct (dat 16, last 1, err 1).
REQ-032 The FIFO SHALL be the sub-module fec_sync_fifo (parameters width and address width; outputs full, empty, count).

Verification
REQ-033 Send a 10-word frame 0x0000..0x0009 with pld_ready_i=1 -> ack per beat; hdr_etype_o=0x0006; FIFO outputs 0x0000..0x0009 with last on 0x0009 and err=0 (strip build: 0x0007..0x0009).
REQ-034 Send a 10-word frame ending with a status word 0x0002 -> last entry has pld_err_o=1.
REQ-035 Send a 4-word runt -> last on word 3 with err=1; hdr_valid_o never pulses.
REQ-036 Hold pld_ready_i=0 and stream 20 words -> snk_stall_o rises at occupancy 14; no data lost; release -> all 20 words delivered in order.
REQ-037 Send a 800-word frame -> words 759..799 dropped; last entry err=1.
REQ-038 Assert rst_sys_i at word 5 then send a clean 8-word frame -> only the clean frame appears, err=0.

Source files
------------

// File: rtl/fec_pkg.sv
// fec_pkg: shared constants and types for the FEC fabric sink.
// Holds fabric word-type codes, the status error bit, FSM states and the FIFO entry layout.
package fec_pkg;

    // Fabric word types carried on snk_adr_i
    localparam logic [1:0] C_ADR_DATA   = 2'd0;
    localparam logic [1:0] C_ADR_OOB    = 2'd1;
    localparam logic [1:0] C_ADR_STATUS = 2'd2;
    localparam logic [1:0] C_ADR_USER   = 2'd3;

    // Bit of a status word that flags a bad frame
    localparam int C_STS_ERR_BIT = 1;

    // Data words 0..6 form the header; word 6 is the ethertype
    localparam logic [10:0] C_HDR_WORDS = 11'd7;
    localparam logic [10:0] C_CNT_SAT   = 11'h7FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_PLD   = 2'd2,
        ST_FLUSH = 2'd3
    } fsm_state_t;

    typedef struct packed {
        logic [15:0] dat;
        logic        last;
        logic        err;
    } fifo_ent_t;

endpackage

// File: rtl/fec_sync_fifo.sv
// fec_sync_fifo: single-clock first-word-fall-through FIFO.
// Ports: clk_i, rst_i (sync, active-high), wr_en_i/wr_dat_i, rd_en_i/rd_dat_o, full_o, empty_o, count_o.
module fec_sync_fifo #(
    parameter int DW = 18,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_dat_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_wr;
    logic          w_rd;

    assign w_wr = wr_en_i & ~full_o;
    assign w_rd = rd_en_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            // push and pop together leave occupancy unchanged
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr) r_mem[r_wptr] <= wr_dat_i;
    end

    assign rd_dat_o = r_mem[r_rptr];
    // count never exceeds DEPTH, so its MSB alone means full
    assign full_o   = r_count[AW];
    assign empty_o  = (r_count == '0);
    assign count_o  = r_count;

endmodule

// File: rtl/fec_fabric_snk.sv
// fec_fabric_snk: pipelined Wishbone fabric sink feeding the FEC encoder payload FIFO.
// Ports: clk_sys_i, rst_sys_i (sync, active-high); snk_* fabric sink; pld_* FWFT payload
// stream; hdr_etype_o/hdr_valid_o ethertype strobe. Define FEC_FABRIC_SNK_HDR_STRIP_EN to
// keep header words 0-6 out of the payload FIFO.
module fec_fabric_snk #(
    parameter int FIFO_AW   = 4,
    parameter int MAX_WORDS = 759
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [15:0] snk_dat_i,
    input  logic [1:0]  snk_sel_i,
    output logic        snk_ack_o,
    output logic        snk_stall_o,
    output logic [15:0] pld_dat_o,
    output logic        pld_last_o,
    output logic        pld_err_o,
    output logic        pld_valid_o,
    input  logic        pld_ready_i,
    output logic [15:0] hdr_etype_o,
    output logic        hdr_valid_o
);

    import fec_pkg::*;

    localparam logic [FIFO_AW:0] C_STALL_LVL = (FIFO_AW+1)'((1 << FIFO_AW) - 2);
    localparam logic [10:0]      C_MAX       = 11'(MAX_WORDS);

    fsm_state_t       r_state;
    logic             r_cyc_d;
    logic             r_ack;
    logic             r_hdr_vld;
    logic [15:0]      r_etype;
    logic [10:0]      r_cnt;
    logic             r_err;
    logic [15:0]      r_pend_dat;
    logic             r_pend_vld;

    logic             w_acc;
    logic             w_stall;
    logic             w_fall;
    logic             w_data;
    logic             w_keep;
    logic             w_runt;
    logic             w_pend_ok;
    logic             w_push;
    logic             w_pop;
    logic [15:0]      w_dat;
    fifo_ent_t        w_push_ent;
    fifo_ent_t        w_pop_ent;
    logic [FIFO_AW:0] w_count;
    logic             w_full;
    logic             w_empty;

    assign w_stall = rst_sys_i | w_full | (w_count >= C_STALL_LVL)
                   | (r_state == ST_FLUSH);
    assign w_acc   = snk_cyc_i & snk_stb_i & snk_we_i & ~w_stall;
    assign w_fall  = r_cyc_d & ~snk_cyc_i;
    assign w_data  = w_acc & (snk_adr_i == C_ADR_DATA);
    // words past MAX_WORDS are acked but dropped
    assign w_keep  = w_data & (r_cnt < C_MAX);
    assign w_runt  = r_cnt < C_HDR_WORDS;
    // lanes not selected are zeroed so a short final word carries no stale byte
    assign w_dat   = {snk_sel_i[1] ? snk_dat_i[15:8] : 8'h00,
                      snk_sel_i[0] ? snk_dat_i[7:0]  : 8'h00};

`ifdef FEC_FABRIC_SNK_HDR_STRIP_EN
    logic r_pend_hdr;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_pend_hdr <= 1'b0;
        end else if (w_keep && r_state != ST_FLUSH) begin
            r_pend_hdr <= (r_cnt < C_HDR_WORDS);
        end
    end

    assign w_pend_ok = ~r_pend_hdr;
`else
    assign w_pend_ok = 1'b1;
`endif

    // The pending word is only known to be last once the cycle ends,
    // so every data word waits here until its successor or FLUSH.
    always_comb begin
        w_push     = 1'b0;
        w_push_ent = '0;
        if (r_state == ST_FLUSH) begin
            w_push     = r_pend_vld & w_pend_ok;
            w_push_ent = '{dat: r_pend_dat, last: 1'b1, err: r_err | w_runt};
        end else if (w_keep) begin
            w_push     = r_pend_vld & w_pend_ok;
            w_push_ent = '{dat: r_pend_dat, last: 1'b0, err: 1'b0};
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state    <= ST_IDLE;
            r_cyc_d    <= 1'b0;
            r_ack      <= 1'b0;
            r_hdr_vld  <= 1'b0;
            r_etype    <= 16'h0000;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_pend_dat <= 16'h0000;
            r_pend_vld <= 1'b0;
        end else begin
            r_cyc_d   <= snk_cyc_i;
            r_ack     <= w_acc;
            r_hdr_vld <= 1'b0;

            unique case (r_state)
                ST_IDLE:  if (snk_cyc_i) r_state <= ST_HDR;
                ST_HDR: begin
                    if (w_fall)
                        r_state <= ST_FLUSH;
                    else if (w_data && r_cnt == C_HDR_WORDS - 11'd1)
                        r_state <= ST_PLD;
                end
                ST_PLD:   if (w_fall) r_state <= ST_FLUSH;
                ST_FLUSH: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase

            if (r_state == ST_FLUSH) begin
                r_cnt      <= '0;
                r_err      <= 1'b0;
                r_pend_vld <= 1'b0;
            end else begin
                if (w_data) begin
                    if (r_cnt != C_CNT_SAT) r_cnt <= r_cnt + 11'd1;
                    if (w_keep) begin
                        r_pend_dat <= w_dat;
                        r_pend_vld <= 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == C_HDR_WORDS - 11'd1) begin
                        r_etype   <= w_dat;
                        r_hdr_vld <= 1'b1;
                    end
                end
                if (w_acc && snk_adr_i == C_ADR_STATUS
                    && snk_dat_i[C_STS_ERR_BIT])
                    r_err <= 1'b1;
            end
        end
    end

    fec_sync_fifo #(
        .DW ($bits(fifo_ent_t)),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i    (clk_sys_i),
        .rst_i    (rst_sys_i),
        .wr_en_i  (w_push),
        .wr_dat_i (w_push_ent),
        .rd_en_i  (w_pop),
        .rd_dat_o (w_pop_ent),
        .full_o   (w_full),
        .empty_o  (w_empty),
        .count_o  (w_count)
    );

    assign pld_valid_o = ~w_empty & ~rst_sys_i;
    assign w_pop       = pld_valid_o & pld_ready_i;
    assign pld_dat_o   = pld_valid_o ? w_pop_ent.dat : 16'h0000;
    assign pld_last_o  = pld_valid_o & w_pop_ent.last;
    assign pld_err_o   = pld_valid_o & w_pop_ent.err;

    assign snk_ack_o   = r_ack & ~rst_sys_i;
    assign snk_stall_o = w_stall;
    assign hdr_valid_o = r_hdr_vld & ~rst_sys_i;
    assign hdr_etype_o = rst_sys_i ? 16'h0000 : r_etype;

endmodule

// File: tb/tb_fec_fabric_snk.sv
// tb_fec_fabric_snk: scoreboard bench for the FEC fabric sink.
// Expected payload entries are queued when a frame is driven and popped at FIFO output.
`timescale 1ns/1ps
module tb_fec_fabric_snk;

    localparam int MAXW = 759;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  adr = 2'd0;
    logic [15:0] dat = 16'h0;
    logic [1:0]  sel = 2'b11;
    logic        ready = 1'b0;

    logic        snk_ack_o, snk_stall_o;
    logic [15:0] pld_dat_o, hdr_etype_o;
    logic        pld_last_o, pld_err_o, pld_valid_o, hdr_valid_o;

    always #5 clk = ~clk;

    fec_fabric_snk #(.FIFO_AW(4), .MAX_WORDS(MAXW)) dut (
        .clk_sys_i   (clk),
        .rst_sys_i   (rst),
        .snk_cyc_i   (cyc),
        .snk_stb_i   (stb),
        .snk_we_i    (we),
        .snk_adr_i   (adr),
        .snk_dat_i   (dat),
        .snk_sel_i   (sel),
        .snk_ack_o   (snk_ack_o),
        .snk_stall_o (snk_stall_o),
        .pld_dat_o   (pld_dat_o),
        .pld_last_o  (pld_last_o),
        .pld_err_o   (pld_err_o),
        .pld_valid_o (pld_valid_o),
        .pld_ready_i (ready),
        .hdr_etype_o (hdr_etype_o),
        .hdr_valid_o (hdr_valid_o)
    );

    typedef struct {
        logic [1:0]  adr;
        logic [15:0] dat;
    } beat_t;

    beat_t       bq[$];
    logic [17:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          hdr_cnt = 0;
    logic [15:0] hdr_val = 16'h0;
    int          ack_cnt = 0;
    int          ack_bad = 0;
    bit          exp_ack = 1'b0;
    int          stall_at = -1;
    bit          drv_timeout = 1'b0;

    // ack must follow each accepted beat by exactly one cycle
    always @(posedge clk)
        exp_ack <= !rst && cyc && stb && we && !snk_stall_o;

    always @(negedge clk) begin
        if (snk_ack_o === 1'b1) ack_cnt++;
        if (snk_ack_o !== exp_ack) ack_bad++;
        if (hdr_valid_o === 1'b1) begin
            hdr_cnt++;
            hdr_val = hdr_etype_o;
        end
    end

    function automatic bit keep_idx(input int idx);
`ifdef FEC_FABRIC_SNK_HDR_STRIP_EN
        return idx >= 7;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void add_beats(input logic [1:0] a, input int n,
                                      input int base);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.adr = a;
            b.dat = 16'(base + k);
            bq.push_back(b);
        end
    endfunction

    // reference model of what one fabric cycle should put in the FIFO
    function automatic void build_exp();
        int nd;
        bit err;
        int lst;
        nd = 0;
        err = 1'b0;
        foreach (bq[k]) begin
            if (bq[k].adr == 2'd0) begin
                if (nd >= MAXW) err = 1'b1;
                else if (keep_idx(nd)) exp_q.push_back({bq[k].dat, 2'b00});
                nd++;
            end else if (bq[k].adr == 2'd2 && bq[k].dat[1]) begin
                err = 1'b1;
            end
        end
        if (nd < 7) err = 1'b1;
        if (exp_q.size() > 0) begin
            lst = exp_q.size() - 1;
            exp_q[lst] = {exp_q[lst][17:2], 1'b1, err};
        end
    endfunction

    task automatic drive(input bit keep_cyc);
        int i;
        int guard;
        i = 0;
        guard = 0;
        stall_at = -1;
        @(posedge clk);
        #1;
        cyc = 1'b1;
        while (i < bq.size() && guard < 5000) begin
            stb = 1'b1;
            we  = 1'b1;
            adr = bq[i].adr;
            dat = bq[i].dat;
            @(negedge clk);
            if (snk_stall_o && stall_at < 0) stall_at = i;
            if (!snk_stall_o) i++;
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) drv_timeout = 1'b1;
        stb = 1'b0;
        we  = 1'b0;
        if (!keep_cyc) cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_pop(output logic [17:0] obs, output bit ok);
        ok = 1'b0;
        obs = '0;
        for (int c = 0; c < 4000 && !ok; c++) begin
            @(negedge clk);
            if (pld_valid_o && ready) begin
                obs = {pld_dat_o, pld_last_o, pld_err_o};
                ok = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (snk_ack_o !== 1'b0 || snk_stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ctl: ack=%b stall=%b want ack=0 stall=1",
                     snk_ack_o, snk_stall_o);
        end
        n_cmp++;
        if ({pld_valid_o, pld_last_o, pld_err_o, hdr_valid_o} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_flags: v/l/e/h=%b%b%b%b want 0000",
                     pld_valid_o, pld_last_o, pld_err_o, hdr_valid_o);
        end
        n_cmp++;
        if (pld_dat_o !== 16'h0 || hdr_etype_o !== 16'h0) begin
            n_bad++;
            $display("FAIL rst_data: dat=%h etype=%h want 0000 0000",
                     pld_dat_o, hdr_etype_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (snk_stall_o !== 1'b0 || pld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL post_rst: stall=%b valid=%b want 0 0",
                     snk_stall_o, pld_valid_o);
        end
    endtask

    task automatic test_basic();
        int a0, h0;
        ready = 1'b1;
        bq.delete();
        exp_q.delete();
        add_beats(2'd0, 10, 0);
        build_exp();
        a0 = ack_cnt;
        h0 = hdr_cnt;
        fork
            drive(1'b0);
            begin : col
                logic [17:0] obs, e;
                bit ok;
                while (exp_q.size() > 0) begin
                    wait_pop(obs, ok);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (!ok || obs !== e) begin
                        n_bad++;
                        $display("FAIL basic_ent: got %h ok=%0d want %h", obs, ok, e);
                        if (!ok) exp_q.delete();
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_extra: valid=%b want 0", pld_valid_o);
        end
        n_cmp++;
        if (ack_cnt - a0 !== 10) begin
            n_bad++;
            $display("FAIL basic_acks: got %0d want 10", ack_cnt - a0);
        end
        n_cmp++;
        if (hdr_cnt - h0 !== 1 || hdr_val !== 16'h0006) begin
            n_bad++;
            $display("FAIL basic_hdr: pulses=%0d etype=%h want 1 0006",
                     hdr_cnt - h0, hdr_val);
        end
    endtask

    task automatic test_status_err();
        beat_t b;
        int a0;
        ready = 1'b1;
        bq.delete();
        exp_q.delete();
        add_beats(2'd0, 9, 16'h2000);
        b.adr = 2'd2;
        b.dat = 16'h0002;
        bq.push_back(b);
        build_exp();
        a0 = ack_cnt;
        fork
            drive(1'b0);
            begin : col
                logic [17:0] obs, e;
                bit ok;
                while (exp_q.size() > 0) begin
                    wait_pop(obs, ok);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (!ok || obs !== e) begin
                        n_bad++;
                        $display("FAIL sts_ent: got %h ok=%0d want %h", obs, ok, e);
                        if (!ok) exp_q.delete();
                    end
                end
            end
        join
        n_cmp++;
        if (ack_cnt - a0 !== 10) begin
            n_bad++;
            $display("FAIL sts_acks: got %0d want 10", ack_cnt - a0);
        end
    endtask

    task automatic test_oob_user();
        int h0;
        ready = 1'b1;
        bq.delete();
        exp_q.delete();
        add_beats(2'd0, 3, 16'h3000);
        add_beats(2'd1, 1, 16'hDEAD);
        add_beats(2'd0, 3, 16'h3003);
        add_beats(2'd3, 1, 16'hBEEF);
        add_beats(2'd2, 1, 16'h0001);
        add_beats(2'd0, 2, 16'h3006);
        build_exp();
        h0 = hdr_cnt;
        fork
            drive(1'b0);
            begin : col
                logic [17:0] obs, e;
                bit ok;
                while (exp_q.size() > 0) begin
                    wait_pop(obs, ok);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (!ok || obs !== e) begin
                        n_bad++;
                        $display("FAIL oob_ent: got %h ok=%0d want %h", obs, ok, e);
                        if (!ok) exp_q.delete();
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL oob_extra: valid=%b want 0", pld_valid_o);
        end
        n_cmp++;
        if (hdr_cnt - h0 !== 1 || hdr_val !== 16'h3006) begin
            n_bad++;
            $display("FAIL oob_hdr: pulses=%0d etype=%h want 1 3006",
                     hdr_cnt - h0, hdr_val);
        end
    endtask

    task automatic test_runt();
        int h0;
        ready = 1'b1;
        bq.delete();
        exp_q.delete();
        add_beats(2'd0, 4, 16'h4000);
        build_exp();
        h0 = hdr_cnt;
        fork
            drive(1'b0);
            begin : col
                logic [17:0] obs, e;
                bit ok;
                while (exp_q.size() > 0) begin
                    wait_pop(obs, ok);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (!ok || obs !== e) begin
                        n_bad++;
                        $display("FAIL runt_ent: got %h ok=%0d want %h", obs, ok, e);
                        if (!ok) exp_q.delete();
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL runt_extra: valid=%b want 0", pld_valid_o);
        end
        n_cmp++;
        if (hdr_cnt !== h0) begin
            n_bad++;
            $display("FAIL runt_hdr: pulses=%0d want 0", hdr_cnt - h0);
        end
    endtask

    task automatic test_stall();
        int exp_stall, pushed;
        ready = 1'b0;
        bq.delete();
        exp_q.delete();
        add_beats(2'd0, 20, 16'h5100);
        build_exp();
        exp_stall = -1;
        for (int n = 1; n <= 20; n++) begin
            pushed = 0;
            for (int k = 0; k < n - 1; k++)
                if (keep_idx(k)) pushed++;
            if (pushed >= 14 && exp_stall < 0) exp_stall = n;
        end
        fork
            drive(1'b0);
            begin
                repeat (60) @(posedge clk);
                #1;
                ready = 1'b1;
            end
            begin : col
                logic [17:0] obs, e;
                bit ok;
                while (exp_q.size() > 0) begin
                    wait_pop(obs, ok);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (!ok || obs !== e) begin
                        n_bad++;
                        $display("FAIL stall_ent: got %h ok=%0d want %h", obs, ok, e);
                        if (!ok) exp_q.delete();
                    end
                end
            end
        join
        n_cmp++;
        if (stall_at !== exp_stall) begin
            n_bad++;
            $display("FAIL stall_point: stalled after %0d beats want %0d",
                     stall_at, exp_stall);
        end
    endtask

    task automatic test_overflow();
        ready = 1'b1;
        bq.delete();
        exp_q.delete();
        add_beats(2'd0, 800, 16'h6000);
        build_exp();
        fork
            drive(1'b0);
            begin : col
                logic [17:0] obs, e;
                bit ok;
                while (exp_q.size() > 0) begin
                    wait_pop(obs, ok);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (!ok || obs !== e) begin
                        n_bad++;
                        $display("FAIL ovf_ent: got %h ok=%0d want %h", obs, ok, e);
                        if (!ok) exp_q.delete();
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_extra: valid=%b want 0", pld_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        bq.delete();
        exp_q.delete();
        add_beats(2'd0, 5, 16'h7000);
        drive(1'b1);
        rst = 1'b1;
        cyc = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pld_valid_o !== 1'b0 || snk_stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_out: valid=%b stall=%b want 0 1",
                     pld_valid_o, snk_stall_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_flush: valid=%b dat=%h want 0",
                     pld_valid_o, pld_dat_o);
        end
        bq.delete();
        add_beats(2'd0, 8, 16'h8000);
        build_exp();
        fork
            drive(1'b0);
            begin : col
                logic [17:0] obs, e;
                bit ok;
                while (exp_q.size() > 0) begin
                    wait_pop(obs, ok);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (!ok || obs !== e) begin
                        n_bad++;
                        $display("FAIL midrst_ent: got %h ok=%0d want %h", obs, ok, e);
                        if (!ok) exp_q.delete();
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pld_valid_o !== 1'b0 || hdr_val !== 16'h8006) begin
            n_bad++;
            $display("FAIL midrst_tail: valid=%b etype=%h want 0 8006",
                     pld_valid_o, hdr_val);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_status_err();
        test_oob_user();
        test_runt();
        test_stall();
        test_overflow();
        test_reset_mid();
        n_cmp++;
        if (ack_bad !== 0) begin
            n_bad++;
            $display("FAIL ack_timing: %0d bad cycles want 0", ack_bad);
        end
        n_cmp++;
        if (drv_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL drv_budget: driver timed out=%b want 0", drv_timeout);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
